// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: FSM states, opcodes,
// ALU operations, datapath mux selects and the DECODE dispatch helper.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_JAL_PC   = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLT = 4'b0101,
        ALU_SLL = 4'b0110,
        ALU_SRL = 4'b0111,
        ALU_SRA = 4'b1000
    } alu_ctrl_t;

    // Operation class handed to the ALU decoder by the FSM.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ITYPE = 2'b11
    } alu_op_t;

    localparam logic [1:0] RSRC_ALUOUT = 2'b00;
    localparam logic [1:0] RSRC_DATA   = 2'b01;
    localparam logic [1:0] RSRC_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_RS1    = 2'b01;

    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_ZERO   = 2'b11;

    // Illegal funct3 codes are caught here so the execute states never see them.
    function automatic state_t decode_target(logic [6:0] opcode, logic [2:0] funct3);
        case (opcode)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_RTYPE:          return (funct3 == 3'b011) ? S_TRAP : S_EXEC_R;
            OP_ITYPE:          return (funct3 == 3'b011) ? S_TRAP : S_EXEC_I;
            OP_BRANCH:         return (funct3 == 3'b000) ? S_BEQ : S_TRAP;
            OP_JAL:            return S_JAL;
            default:           return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle between multicycle_ctrl (master) and the RV32 datapath.
// MULTICYCLE_CTRL_PERF_EN adds the cycle_cnt/instret_cnt counter outputs.
interface multicycle_ctrl_if;

    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        stall;
    logic        mem_write;
    logic        reg_write;
    logic        ir_write;
    logic        pc_write;
    logic        instruction_or_data;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_control;
    logic        illegal_instr;
    logic [3:0]  state_o;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    modport master (
        input  instr, zero, mem_ready, stall,
        output mem_write, reg_write, ir_write, pc_write, instruction_or_data,
        output result_src, alu_src_a, alu_src_b, alu_control, illegal_instr, state_o
`ifdef MULTICYCLE_CTRL_PERF_EN
        , output cycle_cnt, instret_cnt
`endif
    );

    modport slave (
        output instr, zero, mem_ready, stall,
        input  mem_write, reg_write, ir_write, pc_write, instruction_or_data,
        input  result_src, alu_src_a, alu_src_b, alu_control, illegal_instr, state_o
`ifdef MULTICYCLE_CTRL_PERF_EN
        , input cycle_cnt, instret_cnt
`endif
    );

endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps op class plus funct3/funct7b5 to alu_control.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output alu_ctrl_t  alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            default: begin
                case (funct3_i)
                    // Immediate forms have no SUB; funct7b5 there is immediate data.
                    3'b000:  alu_control_o = (alu_op_i == ALUOP_RTYPE && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_control_o = ALU_AND;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b100:  alu_control_o = ALU_XOR;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b001:  alu_control_o = ALU_SLL;
                    3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32 datapath (lw, sw, R/I ALU, beq, jal).
// Define MULTICYCLE_CTRL_PERF_EN to add cycle and retired-instruction counters.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input logic               clk,
    input logic               reset,
    multicycle_ctrl_if.master ctrl
);

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    alu_op_t    alu_op;
    alu_ctrl_t  alu_control;
    logic       mem_write, reg_write, ir_write, pc_write, iord;
    logic [1:0] result_src, alu_src_a, alu_src_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!ctrl.stall) begin
            case (state_q)
                S_FETCH:    if (ctrl.mem_ready) state_d = S_DECODE;
                S_DECODE:   state_d = decode_target(ctrl.instr[6:0], ctrl.instr[14:12]);
                S_MEMADR:   state_d = (ctrl.instr[6:0] == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (ctrl.mem_ready) state_d = S_MEMWB;
                S_MEMWB:    state_d = S_FETCH;
                S_MEMWRITE: if (ctrl.mem_ready) state_d = S_FETCH;
                S_EXEC_R:   state_d = S_ALUWB;
                S_EXEC_I:   state_d = S_ALUWB;
                S_ALUWB:    state_d = S_FETCH;
                S_BEQ:      state_d = S_FETCH;
                S_JAL:      state_d = S_JAL_PC;
                S_JAL_PC:   state_d = S_FETCH;
                S_TRAP:     state_d = S_TRAP;
                default:    state_d = S_TRAP;
            endcase
        end
    end

    assign illegal_d = illegal_q | (state_d == S_TRAP);

    always_comb begin
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        iord       = 1'b0;
        result_src = RSRC_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RSRC_ALURES;
                ir_write   = ctrl.mem_ready;
                pc_write   = ctrl.mem_ready;
            end
            S_DECODE:   alu_src_b = SRCB_IMM;
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  iord = 1'b1;
            S_MEMWB: begin
                result_src = RSRC_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                iord      = 1'b1;
                mem_write = ctrl.mem_ready;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_RTYPE;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ITYPE;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                pc_write  = ctrl.zero;
            end
            S_JAL: begin
                alu_src_b  = SRCB_ZERO;
                result_src = RSRC_ALURES;
                reg_write  = 1'b1;
            end
            S_JAL_PC: begin
                alu_src_b = SRCB_IMM;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
        // A stalled cycle must never commit anything, whatever the state wants.
        if (ctrl.stall) begin
            mem_write = 1'b0;
            reg_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (ctrl.instr[14:12]),
        .funct7b5_i    (ctrl.instr[30]),
        .alu_control_o (alu_control)
    );

    // Reset gates the outputs combinationally so an aborted access cannot write.
    assign ctrl.mem_write           = mem_write & ~reset;
    assign ctrl.reg_write           = reg_write & ~reset;
    assign ctrl.ir_write            = ir_write & ~reset;
    assign ctrl.pc_write            = pc_write & ~reset;
    assign ctrl.instruction_or_data = iord & ~reset;
    assign ctrl.result_src          = reset ? RSRC_ALUOUT : result_src;
    assign ctrl.alu_src_a           = reset ? SRCA_PC : alu_src_a;
    assign ctrl.alu_src_b           = reset ? SRCB_RS2 : alu_src_b;
    assign ctrl.alu_control         = reset ? ALU_ADD : alu_control;
    assign ctrl.illegal_instr       = illegal_q;
    assign ctrl.state_o             = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, instret_cnt_q;
    logic        retire;

    always_comb begin
        retire = (state_d == S_FETCH) &&
                 (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ, S_JAL_PC});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (retire) instret_cnt_q <= instret_cnt_q + 32'd1;
        end
    end

    assign ctrl.cycle_cnt   = cycle_cnt_q;
    assign ctrl.instret_cnt = instret_cnt_q;
`else
    // Counter outputs are absent from the bundle in this build.
`endif

endmodule
